pipeline_flow_ctrl: RTL
=======================

PIPELINE_FLOW_CTRL -- requirements
Module: pipeline_flow_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2: bubble cycles inserted per taken branch (legal 1..7).
REQ-002 SHALL have parameter STALL_MAX, default 15: consecutive stall cycles that raise stall_timeout (legal 1..255).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port dec_dest  in  3  destination register of the instruction in decode.
REQ-006 SHALL have port dec_wr_en  in  1  decode instruction writes dec_dest.
REQ-007 SHALL have port dec_mem_read  in  1  decode instruction is a load.
REQ-008 SHALL have port pipline_stall_n  in  1  stall request from hazard detection; active-high despite its name.
REQ-009 SHALL have port branch_taken  in  1  branch in EX resolved taken this cycle.
REQ-010 SHALL have ports ex_op_dest, mem_op_dest, wb_op_dest  out  3 each  in-flight destinations; 0 means none.
REQ-011 SHALL have port mem_or_reg  out  1  instruction in EX is a load.
REQ-012 SHALL have ports pc_en, ifid_en, ifid_flush  out  1 each  PC write enable, IF/ID write enable, IF/ID clear.
REQ-013 SHALL have ports stall_cycles, flush_events  out  8 each  saturating performance counters.
REQ-014 SHALL have port stall_timeout  out  1  sticky watchdog flag.

Function
REQ-015 SHALL implement FSM states RUN, FLUSH; register flush_cnt is 3 bits.
REQ-016 SHALL define bubble = branch_taken in RUN, or pipline_stall_n in RUN, or state FLUSH.
REQ-017 SHALL shift each edge: wb_op_dest<=mem_op_dest, mem_op_dest<=ex_op_dest, ex_op_dest<=(bubble or !dec_wr_en) ? 0 : dec_dest; mem_or_reg<=bubble ? 0 : dec_mem_read.
REQ-018 SHALL force ex_op_dest to 0 when dec_dest is 0 regardless of dec_wr_en.
REQ-019 SHALL drive pc_en, ifid_en, ifid_flush combinationally from state and inputs; all other outputs registered.
REQ-020 In RUN with branch_taken: pc_en=1, ifid_en=1, ifid_flush=1; branch_taken has priority over pipline_stall_n.
REQ-021 In RUN with branch_taken and FLUSH_DEPTH>1: next state FLUSH, flush_cnt<=FLUSH_DEPTH-1; FLUSH_DEPTH=1: stay RUN.
REQ-022 In RUN with pipline_stall_n and no branch: pc_en=0, ifid_en=0, ifid_flush=0.
REQ-023 In RUN otherwise: pc_en=1, ifid_en=1, ifid_flush=0.
REQ-024 In FLUSH: pc_en=1, ifid_en=1, ifid_flush=1; pipline_stall_n and branch_taken ignored; flush_cnt decrements; at flush_cnt==1 next state RUN.
REQ-025 stall_cycles SHALL increment on each REQ-022 cycle, saturating at 255.
REQ-026 flush_events SHALL increment on each REQ-020 cycle, saturating at 255.
REQ-027 SHALL keep an 8-bit consecutive-stall counter: +1 on REQ-022 cycles, cleared otherwise; stall_timeout set when it reaches STALL_MAX, held until reset.

Reset
REQ-028 On rst: state RUN, flush_cnt 0, all dest outputs 0, mem_or_reg 0, counters 0, stall_timeout 0; pc_en=ifid_en=1, ifid_flush=0 while rst high.
REQ-029 rst asserted mid-FLUSH or mid-stall SHALL abort immediately; first post-reset edge behaves as RUN.

Structure
REQ-030 SHALL place state encoding (RUN, FLUSH), register-address width 3 and counter width 8 in the shared pipeline package.
REQ-031 SHALL use one sub-module sat_counter (8-bit, inc, clear, async reset), instantiated three times (stall_cycles, flush_events, consecutive-stall).

Verification
REQ-032 dec_dest=3,wr_en=1 for 3 idle cycles -> ex/mem/wb_op_dest = 3,0,0 then 3,3,0 then 3,3,3.
REQ-033 load dec_dest=5, then pipline_stall_n=1 one cycle -> pc_en=ifid_en=0 that cycle, next ex_op_dest=0, mem_or_reg=0, mem_op_dest=5, stall_cycles=1.
REQ-034 branch_taken=1 with pipline_stall_n=1, FLUSH_DEPTH=2 -> ifid_flush=1 for 2 cycles, pc_en=1, ex_op_dest=0 for 2 cycles, flush_events=1, stall_cycles unchanged.
REQ-035 pipline_stall_n held 15 cycles -> stall_timeout rises after 15th edge, stays 1 after stall drops; 300 stall cycles -> stall_cycles=255.
REQ-036 rst pulsed during FLUSH -> all outputs at reset values asynchronously; next cycle with branch_taken=0 shows ifid_flush=0.
REQ-037 dec_dest=0, dec_wr_en=1 -> ex_op_dest=0 next cycle.

Source files
------------

// File: rtl/pipeline_flow_ctrl_pkg.sv
// Shared definitions for the pipeline flow controller: widths and FSM state encoding.
package pipeline_flow_ctrl_pkg;

    localparam int REG_W       = 3;
    localparam int CNT_W       = 8;
    localparam int FLUSH_CNT_W = 3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } flow_state_e;

endpackage

// File: rtl/pipeline_flow_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import pipeline_flow_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Stall/flush control for a 5-stage pipeline: tracks in-flight destinations,
// inserts bubbles on stalls and taken branches, and keeps performance counters.
module pipeline_flow_ctrl
    import pipeline_flow_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int STALL_MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] dec_dest,
    input  logic             dec_wr_en,
    input  logic             dec_mem_read,
    input  logic             pipline_stall_n,
    input  logic             branch_taken,
    output logic [REG_W-1:0] ex_op_dest,
    output logic [REG_W-1:0] mem_op_dest,
    output logic [REG_W-1:0] wb_op_dest,
    output logic             mem_or_reg,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             stall_timeout
);

    flow_state_e            state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [REG_W-1:0]       ex_op_dest_q, ex_op_dest_d;
    logic [REG_W-1:0]       mem_op_dest_q, mem_op_dest_d;
    logic [REG_W-1:0]       wb_op_dest_q, wb_op_dest_d;
    logic                   mem_or_reg_q, mem_or_reg_d;
    logic                   stall_timeout_q, stall_timeout_d;
    logic                   bubble;
    logic                   stall_cycle;
    logic                   flush_event;
    logic [CNT_W-1:0]       consec_stalls;

    // Control decode; the enables are held at their idle values while reset is high
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        bubble      = 1'b0;
        stall_cycle = 1'b0;
        flush_event = 1'b0;
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        bubble      = 1'b1;
                        flush_event = 1'b1;
                        if (FLUSH_DEPTH > 1) begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = 3'(FLUSH_DEPTH - 1);
                        end
                    end else if (pipline_stall_n) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        bubble      = 1'b1;
                        stall_cycle = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    ifid_flush  = 1'b1;
                    bubble      = 1'b1;
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q == 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // A zero destination naturally yields "no destination" through the same path
    always_comb begin
        ex_op_dest_d    = (bubble || !dec_wr_en) ? '0 : dec_dest;
        mem_op_dest_d   = ex_op_dest_q;
        wb_op_dest_d    = mem_op_dest_q;
        mem_or_reg_d    = bubble ? 1'b0 : dec_mem_read;
        stall_timeout_d = stall_timeout_q |
                          (stall_cycle && (consec_stalls == 8'(STALL_MAX - 1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_RUN;
            flush_cnt_q     <= '0;
            ex_op_dest_q    <= '0;
            mem_op_dest_q   <= '0;
            wb_op_dest_q    <= '0;
            mem_or_reg_q    <= 1'b0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            ex_op_dest_q    <= ex_op_dest_d;
            mem_op_dest_q   <= mem_op_dest_d;
            wb_op_dest_q    <= wb_op_dest_d;
            mem_or_reg_q    <= mem_or_reg_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    sat_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_cycle),
        .clear (1'b0),
        .count (stall_cycles)
    );

    sat_counter u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_event),
        .clear (1'b0),
        .count (flush_events)
    );

    sat_counter u_consec_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_cycle),
        .clear (!stall_cycle),
        .count (consec_stalls)
    );

    assign ex_op_dest    = ex_op_dest_q;
    assign mem_op_dest   = mem_op_dest_q;
    assign wb_op_dest    = wb_op_dest_q;
    assign mem_or_reg    = mem_or_reg_q;
    assign stall_timeout = stall_timeout_q;

endmodule
